wb_master_seq: RTL and testbench

//  Wishbone classic (B4, non-pipelined) single-transfer bus master; the initiator end
//  of the wbs_* slave interface exposed by the user project macros.

---
 rtl/wb_master_pkg.sv | 12 +
 rtl/wb_master_seq.sv | 147 ++++++++++++++
 tb/tb_wb_master_seq.sv | 264 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/wb_master_pkg.sv
// Shared types for the Wishbone classic single-transfer master.
package wb_master_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUS  = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam int TXN_CNT_W = 16;

endpackage

// File: rtl/wb_master_seq.sv
// Wishbone B4 classic single-transfer master: one command in, one bus cycle, one response out.
// Optional bus timeout abort is enabled by defining WB_MASTER_TIMEOUT_EN.
module wb_master_seq
    import wb_master_pkg::*;
#(
    parameter int AW             = 32,
    parameter int DW             = 32,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic                 wb_clk_i,
    input  logic                 wb_rst_ni,
    input  logic                 cmd_valid_i,
    output logic                 cmd_ready_o,
    input  logic                 cmd_we_i,
    input  logic [DW/8-1:0]      cmd_sel_i,
    input  logic [AW-1:0]        cmd_adr_i,
    input  logic [DW-1:0]        cmd_dat_i,
    output logic                 rsp_valid_o,
    input  logic                 rsp_ready_i,
    output logic [DW-1:0]        rsp_dat_o,
    output logic                 rsp_err_o,
    output logic                 wbm_cyc_o,
    output logic                 wbm_stb_o,
    output logic                 wbm_we_o,
    output logic [DW/8-1:0]      wbm_sel_o,
    output logic [AW-1:0]        wbm_adr_o,
    output logic [DW-1:0]        wbm_dat_o,
    input  logic                 wbm_ack_i,
    input  logic [DW-1:0]        wbm_dat_i,
    output logic                 busy_o,
    output logic [TXN_CNT_W-1:0] txn_cnt_o
);

    state_t                 r_state;
    state_t                 w_state_next;
    logic                   r_cyc;
    logic                   r_we;
    logic [DW/8-1:0]        r_sel;
    logic [AW-1:0]          r_adr;
    logic [DW-1:0]          r_wdat;
    logic                   r_rsp_valid;
    logic [DW-1:0]          r_rsp_dat;
    logic                   r_rsp_err;
    logic [TXN_CNT_W-1:0]   r_txn_cnt;
    logic                   w_tmo_hit;

`ifdef WB_MASTER_TIMEOUT_EN
    localparam int TW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    logic [TW-1:0] r_tmo_cnt;

    // Counts ackless BUS cycles; held at zero outside BUS so every transfer starts fresh.
    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            r_tmo_cnt <= '0;
        end else if (r_state != BUS) begin
            r_tmo_cnt <= '0;
        end else if (!wbm_ack_i) begin
            r_tmo_cnt <= r_tmo_cnt + 1'b1;
        end
    end

    assign w_tmo_hit = (r_state == BUS) && (r_tmo_cnt == TW'(TIMEOUT_CYCLES - 1));
`else
    assign w_tmo_hit = 1'b0;
`endif

    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:    if (cmd_valid_i) w_state_next = BUS;
            BUS:     if (wbm_ack_i || w_tmo_hit) w_state_next = RESP;
            RESP:    if (rsp_ready_i) w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    // Ack is tested before the timeout so an ack on the final allowed cycle completes normally.
    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            r_cyc       <= 1'b0;
            r_we        <= 1'b0;
            r_sel       <= '0;
            r_adr       <= '0;
            r_wdat      <= '0;
            r_rsp_valid <= 1'b0;
            r_rsp_dat   <= '0;
            r_rsp_err   <= 1'b0;
            r_txn_cnt   <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (cmd_valid_i) begin
                        r_cyc  <= 1'b1;
                        r_we   <= cmd_we_i;
                        r_sel  <= cmd_sel_i;
                        r_adr  <= cmd_adr_i;
                        r_wdat <= cmd_dat_i;
                    end
                end
                BUS: begin
                    if (wbm_ack_i) begin
                        r_cyc       <= 1'b0;
                        r_rsp_valid <= 1'b1;
                        r_rsp_err   <= 1'b0;
                        r_rsp_dat   <= r_we ? '0 : wbm_dat_i;
                        r_txn_cnt   <= r_txn_cnt + 1'b1;
                    end else if (w_tmo_hit) begin
                        r_cyc       <= 1'b0;
                        r_rsp_valid <= 1'b1;
                        r_rsp_err   <= 1'b1;
                        r_rsp_dat   <= '0;
                    end
                end
                RESP: begin
                    if (rsp_ready_i) begin
                        r_rsp_valid <= 1'b0;
                    end
                end
                default: begin
                    r_cyc <= 1'b0;
                end
            endcase
        end
    end

    assign cmd_ready_o = (r_state == IDLE);
    assign busy_o      = (r_state != IDLE);
    assign rsp_valid_o = r_rsp_valid;
    assign rsp_dat_o   = r_rsp_dat;
    assign rsp_err_o   = r_rsp_err;
    assign wbm_cyc_o   = r_cyc;
    assign wbm_stb_o   = r_cyc;
    assign wbm_we_o    = r_we;
    assign wbm_sel_o   = r_sel;
    assign wbm_adr_o   = r_adr;
    assign wbm_dat_o   = r_wdat;
    assign txn_cnt_o   = r_txn_cnt;

endmodule

// File: tb/tb_wb_master_seq.sv
// Directed self-checking bench for wb_master_seq; covers timeout behaviour when WB_MASTER_TIMEOUT_EN is defined.
module tb_wb_master_seq;

    logic        clk;
    logic        rst_n;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_we;
    logic [3:0]  cmd_sel;
    logic [31:0] cmd_adr;
    logic [31:0] cmd_dat;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_dat;
    logic        rsp_err;
    logic        wbm_cyc;
    logic        wbm_stb;
    logic        wbm_we;
    logic [3:0]  wbm_sel;
    logic [31:0] wbm_adr;
    logic [31:0] wbm_dat_o;
    logic        wbm_ack;
    logic [31:0] wbm_dat_i;
    logic        busy;
    logic [15:0] txn_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    wb_master_seq #(
        .AW             (32),
        .DW             (32),
        .TIMEOUT_CYCLES (8)
    ) dut (
        .wb_clk_i    (clk),
        .wb_rst_ni   (rst_n),
        .cmd_valid_i (cmd_valid),
        .cmd_ready_o (cmd_ready),
        .cmd_we_i    (cmd_we),
        .cmd_sel_i   (cmd_sel),
        .cmd_adr_i   (cmd_adr),
        .cmd_dat_i   (cmd_dat),
        .rsp_valid_o (rsp_valid),
        .rsp_ready_i (rsp_ready),
        .rsp_dat_o   (rsp_dat),
        .rsp_err_o   (rsp_err),
        .wbm_cyc_o   (wbm_cyc),
        .wbm_stb_o   (wbm_stb),
        .wbm_we_o    (wbm_we),
        .wbm_sel_o   (wbm_sel),
        .wbm_adr_o   (wbm_adr),
        .wbm_dat_o   (wbm_dat_o),
        .wbm_ack_i   (wbm_ack),
        .wbm_dat_i   (wbm_dat_i),
        .busy_o      (busy),
        .txn_cnt_o   (txn_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] req);
        n_checks++;
        assert (obs === req) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, req);
        end
    endtask

    initial begin
        rst_n     = 1'b0;
        cmd_valid = 1'b0;
        cmd_we    = 1'b0;
        cmd_sel   = 4'h0;
        cmd_adr   = 32'h0;
        cmd_dat   = 32'h0;
        rsp_ready = 1'b0;
        wbm_ack   = 1'b0;
        wbm_dat_i = 32'h0;

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_cmd_ready", {31'b0, cmd_ready}, 32'd1);
        chk("rst_cyc",       {31'b0, wbm_cyc},   32'd0);
        chk("rst_stb",       {31'b0, wbm_stb},   32'd0);
        chk("rst_rsp_valid", {31'b0, rsp_valid}, 32'd0);
        chk("rst_busy",      {31'b0, busy},      32'd0);
        chk("rst_txn_cnt",   {16'b0, txn_cnt},   32'd0);
        chk("rst_adr",       wbm_adr,            32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // 1: write, ack presented in the third bus cycle
        cmd_valid = 1'b1; cmd_we = 1'b1; cmd_sel = 4'hF;
        cmd_adr = 32'h3000_0004; cmd_dat = 32'hA5A5_1234;
        @(negedge clk);
        cmd_valid = 1'b0;
        chk("t1_cyc_c1",    {31'b0, wbm_cyc},   32'd1);
        chk("t1_stb_c1",    {31'b0, wbm_stb},   32'd1);
        chk("t1_we",        {31'b0, wbm_we},    32'd1);
        chk("t1_sel",       {28'b0, wbm_sel},   32'hF);
        chk("t1_adr",       wbm_adr,            32'h3000_0004);
        chk("t1_dat",       wbm_dat_o,          32'hA5A5_1234);
        chk("t1_cmd_ready", {31'b0, cmd_ready}, 32'd0);
        chk("t1_busy",      {31'b0, busy},      32'd1);
        @(negedge clk);
        chk("t1_cyc_c2",    {31'b0, wbm_cyc},   32'd1);
        chk("t1_rsp_early", {31'b0, rsp_valid}, 32'd0);
        @(negedge clk);
        chk("t1_cyc_c3",    {31'b0, wbm_cyc},   32'd1);
        wbm_ack = 1'b1;
        @(negedge clk);
        wbm_ack = 1'b0;
        chk("t1_cyc_end",   {31'b0, wbm_cyc},   32'd0);
        chk("t1_stb_end",   {31'b0, wbm_stb},   32'd0);
        chk("t1_rsp_valid", {31'b0, rsp_valid}, 32'd1);
        chk("t1_rsp_err",   {31'b0, rsp_err},   32'd0);
        chk("t1_rsp_dat",   rsp_dat,            32'd0);
        chk("t1_txn_cnt",   {16'b0, txn_cnt},   32'd1);
        chk("t1_adr_hold",  wbm_adr,            32'h3000_0004);
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        chk("t1_rsp_clr",   {31'b0, rsp_valid}, 32'd0);
        chk("t1_idle_rdy",  {31'b0, cmd_ready}, 32'd1);
        chk("t1_idle_busy", {31'b0, busy},      32'd0);

        // 2: read, ack in first bus cycle, response held while consumer stalls
        cmd_valid = 1'b1; cmd_we = 1'b0; cmd_adr = 32'h3000_0010; cmd_sel = 4'h3;
        @(negedge clk);
        cmd_valid = 1'b0;
        chk("t2_we",  {31'b0, wbm_we}, 32'd0);
        chk("t2_adr", wbm_adr,         32'h3000_0010);
        wbm_ack = 1'b1; wbm_dat_i = 32'hCAFE_F00D;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk($sformatf("t2_rsp_valid_%0d", i), {31'b0, rsp_valid}, 32'd1);
            chk($sformatf("t2_rsp_dat_%0d", i),   rsp_dat,            32'hCAFE_F00D);
            chk($sformatf("t2_cmd_ready_%0d", i), {31'b0, cmd_ready}, 32'd0);
            chk($sformatf("t2_cyc_%0d", i),       {31'b0, wbm_cyc},   32'd0);
            chk($sformatf("t2_txn_cnt_%0d", i),   {16'b0, txn_cnt},   32'd2);
        end
        wbm_ack = 1'b0;
        rsp_ready = 1'b1;
        @(negedge clk);
        chk("t2_rsp_clr", {31'b0, rsp_valid}, 32'd0);

        // 3: back-to-back reads, ack and rsp_ready held high
        cmd_valid = 1'b1; cmd_we = 1'b0; wbm_ack = 1'b1;
        for (int k = 0; k < 3; k++) begin
            cmd_adr   = 32'h0000_0100 + 32'(4 * k);
            wbm_dat_i = 32'h1111_0000 + 32'(k);
            chk($sformatf("t3_idle_rdy_%0d", k), {31'b0, cmd_ready}, 32'd1);
            @(negedge clk);
            chk($sformatf("t3_cyc_%0d", k), {31'b0, wbm_cyc}, 32'd1);
            chk($sformatf("t3_adr_%0d", k), wbm_adr, 32'h0000_0100 + 32'(4 * k));
            @(negedge clk);
            chk($sformatf("t3_rsp_valid_%0d", k), {31'b0, rsp_valid}, 32'd1);
            chk($sformatf("t3_rsp_dat_%0d", k),   rsp_dat, 32'h1111_0000 + 32'(k));
            chk($sformatf("t3_txn_cnt_%0d", k),   {16'b0, txn_cnt}, 32'd3 + 32'(k));
            chk($sformatf("t3_cyc_off_%0d", k),   {31'b0, wbm_cyc}, 32'd0);
            if (k == 2) cmd_valid = 1'b0;
            @(negedge clk);
        end
        wbm_ack = 1'b0;
        rsp_ready = 1'b0;
        chk("t3_end_idle", {31'b0, busy}, 32'd0);

        // 4: no ack on the bus
        cmd_valid = 1'b1; cmd_we = 1'b1; cmd_adr = 32'h3000_0020; cmd_dat = 32'h1234_5678;
        @(negedge clk);
        cmd_valid = 1'b0;
`ifdef WB_MASTER_TIMEOUT_EN
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("t4_stb_hold_%0d", i), {31'b0, wbm_stb}, 32'd1);
            @(negedge clk);
        end
        chk("t4_stb_drop",  {31'b0, wbm_stb},   32'd0);
        chk("t4_rsp_valid", {31'b0, rsp_valid}, 32'd1);
        chk("t4_rsp_err",   {31'b0, rsp_err},   32'd1);
        chk("t4_rsp_dat",   rsp_dat,            32'd0);
        chk("t4_txn_cnt",   {16'b0, txn_cnt},   32'd5);
        wbm_ack = 1'b1;
        @(negedge clk);
        wbm_ack = 1'b0;
        chk("t4_late_ack_cnt", {16'b0, txn_cnt},   32'd5);
        chk("t4_late_ack_rsp", {31'b0, rsp_valid}, 32'd1);
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        chk("t4_rsp_clr", {31'b0, rsp_valid}, 32'd0);

        // 4b: ack on the last allowed cycle completes normally
        cmd_valid = 1'b1; cmd_we = 1'b0; cmd_adr = 32'h3000_0024;
        @(negedge clk);
        cmd_valid = 1'b0;
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("t4b_stb_hold_%0d", i), {31'b0, wbm_stb}, 32'd1);
            if (i == 7) begin
                wbm_ack = 1'b1; wbm_dat_i = 32'hBEEF_0007;
            end
            @(negedge clk);
        end
        wbm_ack = 1'b0;
        chk("t4b_rsp_err", {31'b0, rsp_err}, 32'd0);
        chk("t4b_rsp_dat", rsp_dat,          32'hBEEF_0007);
        chk("t4b_txn_cnt", {16'b0, txn_cnt}, 32'd6);
`else
        for (int i = 0; i < 20; i++) begin
            chk($sformatf("t4_stb_wait_%0d", i), {31'b0, wbm_stb}, 32'd1);
            @(negedge clk);
        end
        wbm_ack = 1'b1;
        @(negedge clk);
        wbm_ack = 1'b0;
        chk("t4_rsp_valid", {31'b0, rsp_valid}, 32'd1);
        chk("t4_rsp_err",   {31'b0, rsp_err},   32'd0);
        chk("t4_rsp_dat",   rsp_dat,            32'd0);
        chk("t4_txn_cnt",   {16'b0, txn_cnt},   32'd6);
`endif
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;

        // 5: asynchronous reset in the middle of a bus cycle
        cmd_valid = 1'b1; cmd_we = 1'b0; cmd_adr = 32'h3000_0030;
        @(negedge clk);
        cmd_valid = 1'b0;
        chk("t5_cyc_pre", {31'b0, wbm_cyc}, 32'd1);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("t5_cyc",       {31'b0, wbm_cyc},   32'd0);
        chk("t5_stb",       {31'b0, wbm_stb},   32'd0);
        chk("t5_rsp_valid", {31'b0, rsp_valid}, 32'd0);
        chk("t5_cmd_ready", {31'b0, cmd_ready}, 32'd1);
        chk("t5_txn_cnt",   {16'b0, txn_cnt},   32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // 6: counter wrap from 16'hFFFF
        force dut.r_txn_cnt = 16'hFFFF;
        @(negedge clk);
        release dut.r_txn_cnt;
        @(negedge clk);
        chk("t6_preload", {16'b0, txn_cnt}, 32'h0000_FFFF);
        cmd_valid = 1'b1; cmd_we = 1'b1; cmd_adr = 32'h3000_0040;
        @(negedge clk);
        cmd_valid = 1'b0;
        wbm_ack = 1'b1;
        @(negedge clk);
        wbm_ack = 1'b0;
        chk("t6_rsp_valid", {31'b0, rsp_valid}, 32'd1);
        chk("t6_wrap",      {16'b0, txn_cnt},   32'd0);
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
